// File: rtl/mem_pkg.sv
// Shared constants and types for the memory responder slice.
package mem_pkg;

  // Reset vector of the core; the first instruction fetch lands here.
  localparam logic [31:0] PC_ENTRY      = 32'h0001_0054;
  // Default address of RAM byte 0.
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0001_0000;

  // r_len encodings: transfer length minus one.
  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_3B = 2'd2;
  localparam logic [1:0] LEN_4B = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StXfer,
    StResp
  } mem_state_t;

endpackage

// File: rtl/mem_byte_ram.sv
// Single-port byte-wide RAM: synchronous write, combinational read. Contents are not reset.
module mem_byte_ram #(
  parameter int unsigned Depth = 262144,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [Depth];

  // Byte store on the rising edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Cycle-accurate memory responder: serves one 1-4 byte read or write per request from an
// internal byte RAM, one byte per cycle after a fixed wait, then pulses done.
// Build option: define MEM_BSWAP_EN to reverse byte lanes within the transfer (big-endian words).
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned        MADDR_L   = 32,
  parameter int unsigned        DATA_L    = 32,
  parameter int unsigned        MEM_BYTES = 262144,
  parameter logic [MADDR_L-1:0] BASE_ADDR = MADDR_L'(DEF_BASE_ADDR),
  parameter int unsigned        LATENCY   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               re,
  input  logic               we,
  input  logic [MADDR_L-1:0] addr,
  input  logic [1:0]         r_len,
  input  logic [DATA_L-1:0]  wdata,
  output logic [DATA_L-1:0]  dataout,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned Aw      = $clog2(MEM_BYTES);
  localparam logic [3:0]  LatLast = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  mem_state_t        state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic              oor_q, oor_d;
  logic [1:0]        len_q, len_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [Aw-1:0]     off_q, off_d;
  logic [DATA_L-1:0] wdata_q, wdata_d;
  logic [DATA_L-1:0] rdata_q, rdata_d;
  logic [DATA_L-1:0] dataout_q, dataout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [MADDR_L-1:0] off_req;
  logic [MADDR_L:0]   span_end;
  logic               in_range;
  logic [1:0]         lane;
  logic [Aw-1:0]      ram_addr;
  logic               ram_we;
  logic [7:0]         ram_wdata;
  logic [7:0]         ram_rdata;

  // Range check on the raw request: offset of the last byte must stay below MEM_BYTES.
  // Addresses under BASE_ADDR wrap to a huge offset and fail the same comparison.
  always_comb begin
    off_req  = addr - BASE_ADDR;
    span_end = {1'b0, off_req} + (MADDR_L + 1)'(r_len);
    in_range = span_end < (MADDR_L + 1)'(MEM_BYTES);
  end

  // Lane for the current byte offset; timing is the same in both orders.
  always_comb begin
`ifdef MEM_BSWAP_EN
    lane = len_q - idx_q;
`else
    lane = idx_q;
`endif
    ram_addr  = off_q + Aw'(idx_q);
    ram_we    = (state_q == StXfer) && op_wr_q;
    ram_wdata = wdata_q[{lane, 3'b000} +: 8];
  end

  mem_byte_ram #(
    .Depth (MEM_BYTES),
    .Aw    (Aw)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Next-state and output logic; outputs are registered so done/busy/err change on the edge.
  always_comb begin
    state_d   = state_q;
    op_wr_d   = op_wr_q;
    oor_d     = oor_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    dataout_d = dataout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (re || we) begin
          op_wr_d = we;  // write wins when both are raised
          len_d   = r_len;
          off_d   = off_req[Aw-1:0];
          wdata_d = wdata;
          rdata_d = '0;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          oor_d   = !in_range;
          busy_d  = 1'b1;
          if (!in_range) begin
            state_d = StResp;
          end else if (LATENCY == 0) begin
            state_d = StXfer;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == LatLast) begin
          state_d = StXfer;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StXfer: begin
        if (!op_wr_q) begin
          rdata_d[{lane, 3'b000} +: 8] = ram_rdata;
        end
        if (idx_q == len_q) begin
          state_d = StResp;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StResp: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        err_d   = oor_q;
        // dataout only moves here, so it holds steady through the next transfer.
        if (oor_q) begin
          dataout_d = '0;
        end else if (!op_wr_q) begin
          dataout_d = rdata_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; RAM contents are deliberately outside this reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      op_wr_q   <= 1'b0;
      oor_q     <= 1'b0;
      len_q     <= 2'd0;
      idx_q     <= 2'd0;
      cnt_q     <= 4'd0;
      off_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      dataout_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_wr_q   <= op_wr_d;
      oor_q     <= oor_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      dataout_q <= dataout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign dataout = dataout_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of request vectors plus hand-written sequences
// for busy-time requests and mid-transfer reset.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  r_len = '0;
  logic [31:0] wdata = '0;
  logic [31:0] dataout;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  mem_responder #(
    .LATENCY (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .re      (re),
    .we      (we),
    .addr    (addr),
    .r_len   (r_len),
    .wdata   (wdata),
    .dataout (dataout),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;  // bytes in memory order, byte 0 in [7:0]
    logic [31:0] rdata;  // expected read bytes in memory order
    logic        err;
    int          cyc;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory byte order -> bus lane order for the current build.
  function automatic logic [31:0] xf(input logic [31:0] v, input logic [1:0] len);
    logic [31:0] r;
`ifdef MEM_BSWAP_EN
    r = '0;
    for (int i = 0; i <= int'(len); i++) begin
      r[(int'(len) - i) * 8 +: 8] = v[i * 8 +: 8];
    end
`else
    r = v;
    if (len == 2'd3) r = v;  // identity mapping
`endif
    return r;
  endfunction

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [1:0] l, input logic [31:0] wd,
                              input logic [31:0] rd, input logic e, input int c);
    vec_t v;
    v.re = r; v.we = w; v.addr = a; v.len = l;
    v.wdata = wd; v.rdata = rd; v.err = e; v.cyc = c;
    return v;
  endfunction

  // One request: pulse for the accept edge, then wait (bounded) for done.
  task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [1:0] l,
                     input logic [31:0] wd, output logic [31:0] d, output logic e,
                     output int c);
    @(negedge clk);
    re = r; we = w; addr = a; r_len = l; wdata = wd;
    @(posedge clk);
    #1;
    re = 1'b0; we = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    c = 0;
    while (c < 40) begin
      @(posedge clk);
      #1;
      c++;
      if (done) break;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within %0d cycles, want done", c);
    end
    d = dataout;
    e = err;
    check("busy_low_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  logic [31:0] last_dout;
  logic [31:0] exp_d;
  logic [31:0] got_d;
  logic        got_e;
  int          got_c;
  int          ndone;
  int          dcyc;
  logic [31:0] dval;

  initial begin
    //              re    we    addr          len     wdata         rdata         err   cycles
    vecs[0]  = mk(1'b0, 1'b1, PC_ENTRY,     LEN_4B, 32'h0B000013, 32'h0,        1'b0, LAT + 5);
    vecs[1]  = mk(1'b1, 1'b0, PC_ENTRY,     LEN_4B, 32'h0,        32'h0B000013, 1'b0, LAT + 5);
    vecs[2]  = mk(1'b0, 1'b1, 32'h00010100, LEN_4B, 32'hA1B2C3D4, 32'h0,        1'b0, LAT + 5);
    vecs[3]  = mk(1'b0, 1'b1, 32'h00010101, LEN_2B, 32'h0000BEEF, 32'h0,        1'b0, LAT + 3);
    vecs[4]  = mk(1'b1, 1'b0, 32'h00010100, LEN_4B, 32'h0,        32'hA1BEEFD4, 1'b0, LAT + 5);
    vecs[5]  = mk(1'b1, 1'b0, 32'h00010056, LEN_2B, 32'h0,        32'h00000B00, 1'b0, LAT + 3);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0000FFFF, LEN_1B, 32'h0,        32'h0,        1'b1, 1);
    vecs[7]  = mk(1'b1, 1'b0, 32'h0004FFFE, LEN_4B, 32'h0,        32'h0,        1'b1, 1);
    vecs[8]  = mk(1'b0, 1'b1, 32'h0000FFFF, LEN_1B, 32'h00000055, 32'h0,        1'b1, 1);
    vecs[9]  = mk(1'b1, 1'b1, 32'h00010200, LEN_1B, 32'h00000077, 32'h0,        1'b0, LAT + 2);
    vecs[10] = mk(1'b1, 1'b0, 32'h00010200, LEN_1B, 32'h0,        32'h00000077, 1'b0, LAT + 2);
    vecs[11] = mk(1'b0, 1'b1, 32'h0004FFFF, LEN_1B, 32'h0000005A, 32'h0,        1'b0, LAT + 2);
    vecs[12] = mk(1'b1, 1'b0, 32'h0004FFFF, LEN_1B, 32'h0,        32'h0000005A, 1'b0, LAT + 2);
    vecs[13] = mk(1'b1, 1'b0, 32'h00010055, LEN_3B, 32'h0,        32'h000B0000, 1'b0, LAT + 4);
    vecs[14] = mk(1'b1, 1'b0, 32'hFFFFFFFE, LEN_4B, 32'h0,        32'h0,        1'b1, 1);

    // Asynchronous reset and its output values.
    #3 rst = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_dataout", dataout, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    last_dout = 32'd0;
    for (int i = 0; i < NV; i++) begin
      txn(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].len, xf(vecs[i].wdata, vecs[i].len),
          got_d, got_e, got_c);
      if (vecs[i].err) exp_d = 32'd0;
      else if (vecs[i].we) exp_d = last_dout;
      else exp_d = xf(vecs[i].rdata, vecs[i].len);
      last_dout = exp_d;
      check($sformatf("v%0d_dataout", i), got_d, exp_d);
      check($sformatf("v%0d_err", i), {31'd0, got_e}, {31'd0, vecs[i].err});
      check($sformatf("v%0d_cycles", i), got_c, vecs[i].cyc);
    end

    // A second read raised while busy must be ignored: one done, first request's data.
    @(negedge clk);
    re = 1'b1; we = 1'b0; addr = PC_ENTRY; r_len = LEN_4B;
    @(posedge clk);
    #1;
    re = 1'b0;
    ndone = 0;
    dcyc  = 0;
    dval  = '0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          dcyc = k;
          dval = dataout;
        end
      end
      if (k == 2) begin
        re = 1'b1; addr = 32'h00010200; r_len = LEN_1B;
      end
      if (k == 3) re = 1'b0;
    end
    check("busy_req_done_count", ndone, 1);
    check("busy_req_cycles", dcyc, LAT + 5);
    check("busy_req_dataout", dval, xf(32'h0B000013, LEN_4B));

    // Reset during the byte phase of a read aborts it at once.
    @(negedge clk);
    re = 1'b1; addr = PC_ENTRY; r_len = LEN_4B;
    @(posedge clk);
    #1;
    re = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_dataout", dataout, 32'd0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (k == 3) rst = 1'b1;
    end
    check("midrst_no_done", ndone, 0);
    txn(1'b1, 1'b0, PC_ENTRY, LEN_4B, 32'h0, got_d, got_e, got_c);
    check("post_rst_dataout", got_d, xf(32'h0B000013, LEN_4B));
    check("post_rst_err", {31'd0, got_e}, 32'd0);
    check("post_rst_cycles", got_c, LAT + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the fetch/load-store port: accepts single read or write requests of 1-4 bytes, services them from an internal byte-addressed RAM, and returns data with a done pulse.
- Sits between pipeIF/pipeMEM request ports (addr, re, r_len, datain) and backing storage; it replaces the behavioural #delay memory model with a clocked, cycle-accurate one.

Parameters:
- MADDR_L, 32, request address width
- DATA_L, 32, data bus width; fixed to 4 bytes
- MEM_BYTES, 262144, RAM size in bytes; power of two
- BASE_ADDR, 32'h10000, address mapped to RAM byte 0
- LATENCY, 2, wait cycles before the first byte access; legal range 0-15

Ports:
- clk  in  1  clock; rising edge
- rst  in  1  asynchronous, active-low reset
- re  in  1  read request; sampled only in IDLE
- we  in  1  write request; sampled only in IDLE
- addr  in  MADDR_L  byte address of the request
- r_len  in  2  transfer length minus 1 (0=1B, 1=2B, 2=3B, 3=4B); shared by reads and writes
- wdata  in  DATA_L  write data; byte 0 in wdata[7:0]
- dataout  out  DATA_L  read data; byte 0 in dataout[7:0]; unused upper bytes are zero
- busy  out  1  high from the request-accept cycle until done
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; set on an out-of-range access

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; dataout=0, busy=0, done=0, err=0; counters cleared. RAM contents are not reset.
- FSM states: IDLE, WAIT, XFER, RESP.
- IDLE:
  - If re or we is high at a clk edge, latch addr, r_len, wdata and the op, then go to WAIT.
  - When re and we are both high, the write takes priority.
  - busy rises in the accepting cycle (registered, so visible the cycle after the edge).
  - If LATENCY=0, go straight to XFER.
- WAIT: count LATENCY cycles, then go to XFER.
- XFER:
  - Access one byte per cycle at offset i = 0..r_len, address addr-BASE_ADDR+i.
  - Reads shift the byte into dataout lane i. Writes store wdata lane i.
  - After byte r_len, go to RESP.
- RESP:
  - done=1 for exactly one cycle; busy falls in the same cycle.
  - dataout stays stable from RESP until the next read's RESP; writes leave dataout unchanged.
  - Return to IDLE. A new request can be accepted on the following edge.
- Latency: accept edge to done high = LATENCY + (r_len+1) + 1 cycles. The 4-byte read with LATENCY=2 takes 7 cycles.
- Misaligned access is legal; bytes are assembled serially. The offset wraps modulo 2^MADDR_L.
- Range check at accept:
  - The access is out of range if any byte falls outside [BASE_ADDR, BASE_ADDR+MEM_BYTES-1].
  - On out of range, skip WAIT/XFER and go directly to RESP with err=1. The RAM is not written and dataout is forced to 0.
- re/we arriving while busy are ignored; the requester must hold its request until done.
- Reset asserted mid-transaction aborts it: no done pulse is produced. A partial write may leave earlier bytes already written.

Optional Feature:
- Macro MEM_BSWAP_EN.
- Defined: the byte order on dataout and wdata is reversed within the transfer. Byte at offset i maps to lane r_len-i, giving big-endian instruction words.
- Undefined: little-endian lane mapping as described above.
- Timing is identical in both builds.

Decomposition:
- Shared package mem_pkg:
  - PC_ENTRY (32'h10054) and BASE_ADDR default
  - length encodings LEN_1B..LEN_4B
  - FSM state typedef mem_state_t
- One sub-module, mem_byte_ram:
  - single-port, 8-bit, synchronous write, combinational read
  - indexed by the offset address

Test Plan:
- Preload bytes 0x54..0x57 = 13,00,00,0B. Read addr=32'h10054, r_len=3, LATENCY=2 -> done exactly 7 cycles after accept, dataout=32'h0B000013, err=0.
- Write addr=32'h10101, r_len=1, wdata=32'h0000BEEF, then read 4B at 32'h10100 -> dataout[23:8]=16'hBEEF; bytes 0 and 3 unchanged.
- Read addr=32'h0000FFFF, r_len=0 -> done after 1 cycle, err=1, dataout=0, no RAM change. Repeat at BASE_ADDR+MEM_BYTES-2 with r_len=3 -> err=1.
- re and we high together -> write performed. A second re pulsed while busy -> ignored; only one done.
- Assert rst low during XFER -> busy/done/dataout are 0 immediately without a clock edge. A subsequent read completes normally.
- With MEM_BSWAP_EN defined, the first scenario -> dataout=32'h1300000B with the same cycle count.
